ring_decoder: RTL and testbench
===============================

Name: ring_decoder

Overview:
- Receive-side companion to the team's one-hot ring counter.
- Samples a WIDTH-bit ring pattern, converts it to a binary position index, and checks that every step is a single rotate-left of the previous step.
- Counts completed laps, flags malformed and out-of-sequence patterns, and drops lock after repeated faults.
- Sits downstream of any ring-counter source, as a sequencer monitor or a phase decoder.

Parameters:
- WIDTH, 3, ring length in bits (≥2); idx width IW = $clog2(WIDTH).
- LAP_W, 8, lap counter width.
- ERR_LIMIT, 2, consecutive faulty samples in TRACK that force loss of lock (≥1).

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous reset, active-low.
- in_valid  input  1  ring_in is sampled this cycle.
- ring_in  input  WIDTH  ring pattern; bit 0 is position 0.
- idx_out  output  IW  binary position of the last accepted one-hot sample.
- idx_valid  output  1  one-cycle pulse: idx_out updated.
- locked  output  1  decoder is in TRACK.
- seq_err  output  1  one-cycle pulse: one-hot sample that is not the expected successor.
- onehot_err  output  1  one-cycle pulse: sample with popcount ≠ 1.
- lap_count  output  LAP_W  completed laps, modulo 2^LAP_W.

Behaviour:
- All outputs are registered. Response appears on the clock edge that samples in_valid=1; it is visible in the cycle after the sample.
- reset_n=0, asynchronous:
  - state=HUNT, prev=0, miss_cnt=0.
  - idx_out=0, idx_valid=0, locked=0, seq_err=0, onehot_err=0, lap_count=0.
  - Reset mid-operation aborts tracking immediately; no pulse is generated.
- in_valid=0: all pulse outputs are 0; state, prev, miss_cnt, idx_out and lap_count hold.
- expected = rotate-left(prev) by 1, with bit WIDTH-1 wrapping to bit 0.
- HUNT:
  - One-hot sample: idx_out=position, idx_valid=1, prev=sample, miss_cnt=0, go to TRACK, locked=1.
  - Non-one-hot sample (including all-zero): onehot_err=1, idx_valid=0, stay in HUNT.
  - seq_err never asserts in HUNT; lap_count never increments in HUNT.
- TRACK, one-hot sample equal to expected:
  - idx_valid=1, idx_out=position, prev=sample, miss_cnt=0.
  - If prev[WIDTH-1]=1 and sample[0]=1: lap_count increments, wrapping silently.
- TRACK, one-hot sample not equal to expected (repeat of prev included):
  - seq_err=1, idx_valid=1, idx_out=actual position.
  - prev=sample (resync to actual position), miss_cnt+1, no lap increment.
- TRACK, non-one-hot sample:
  - onehot_err=1, idx_valid=0, prev and idx_out unchanged, miss_cnt+1.
- Loss of lock:
  - When miss_cnt+1 reaches ERR_LIMIT, on that same edge: state=HUNT, locked=0, miss_cnt=0.
  - The triggering error pulse still asserts on that edge.
- Behaviour on in_valid gaps:
  - A source that holds its ring state between steps must deassert in_valid. A held-and-valid pattern counts as seq_err.
  - miss_cnt counts consecutive faulty valid samples only; in_valid gaps do not reset it.
- lap_count is cleared only by reset_n; loss of lock does not clear it.
- At most one of seq_err and onehot_err is high in any cycle.

Test Plan:
- Normal sequence (WIDTH=3): reset_n low then high; in_valid=1 with 001,010,100,001,010.
  - idx_out = 0,1,2,0,1, each with idx_valid.
  - locked=1 from the first response.
  - lap_count=1 after the 100→001 step; no errors.
- Skip: locked at 001, then 100, then 001.
  - seq_err pulse with idx_out=2, locked stays 1.
  - Next 001 is accepted cleanly, lap_count increments, miss_cnt cleared.
- Loss of lock (ERR_LIMIT=2): locked at 010, then 011, then 000.
  - Two onehot_err pulses, idx_out stays 1.
  - locked falls on the second error edge.
  - A following 100 re-locks with idx_out=2 and no lap increment.
- Gaps and repeat: 001, in_valid=0 for 3 cycles, 010 → no pulses during the gap, 010 accepted cleanly. Then 010 presented again with in_valid=1 → seq_err.
- Lap wrap (LAP_W=2): run 5 full laps → lap_count sequence 1,2,3,0,1.
- Reset mid-lap: assert reset_n low between clock edges while locked at 010.
  - All outputs go to 0 immediately, without waiting for a clock edge.
  - After release, 100 re-locks with idx_out=2 and lap_count=0.

Source files
------------

// File: rtl/ring_decoder.sv
// Receive-side decoder for a one-hot ring counter: converts each valid sample to a
// binary index, checks rotate-left succession, counts laps and tracks lock.
module ring_decoder #(
   parameter int WIDTH     = 3,
   parameter int LAP_W     = 8,
   parameter int ERR_LIMIT = 2,
   localparam int IW       = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] ring_in,
   output logic [IW-1:0]    idx_out,
   output logic             idx_valid,
   output logic             locked,
   output logic             seq_err,
   output logic             onehot_err,
   output logic [LAP_W-1:0] lap_count
);

   localparam int MW = $clog2(ERR_LIMIT + 1);

   typedef enum logic {HUNT, TRACK} state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   prev_q, prev_d;
   logic [MW-1:0]      miss_q, miss_d;
   logic [IW-1:0]      idx_q, idx_d;
   logic [LAP_W-1:0]   lap_q, lap_d;
   logic               locked_q;
   logic               iv_q, iv_d;
   logic               seq_q, seq_d;
   logic               oh_q, oh_d;

   logic               is_onehot;
   logic               fault;
   logic [IW-1:0]      pos;
   logic [WIDTH-1:0]   expected;
   logic [MW-1:0]      miss_inc;

   // Sample classification: one-hot test, bit position and expected successor.
   always_comb begin
      is_onehot = (ring_in != '0) && ((ring_in & (ring_in - WIDTH'(1))) == '0);
      pos       = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (ring_in[i]) pos = IW'(i);
      end
      expected  = {prev_q[WIDTH-2:0], prev_q[WIDTH-1]};
      miss_inc  = miss_q + MW'(1);
   end

   // Next-state and next-output logic; a fault that reaches the limit drops to HUNT.
   always_comb begin
      state_d = state_q;
      prev_d  = prev_q;
      miss_d  = miss_q;
      idx_d   = idx_q;
      lap_d   = lap_q;
      iv_d    = 1'b0;
      seq_d   = 1'b0;
      oh_d    = 1'b0;
      fault   = 1'b0;
      if (in_valid) begin
         case (state_q)
            HUNT: begin
               if (is_onehot) begin
                  idx_d   = pos;
                  iv_d    = 1'b1;
                  prev_d  = ring_in;
                  miss_d  = '0;
                  state_d = TRACK;
               end else begin
                  oh_d = 1'b1;
               end
            end
            TRACK: begin
               if (is_onehot) begin
                  iv_d   = 1'b1;
                  idx_d  = pos;
                  prev_d = ring_in;
                  if (ring_in == expected) begin
                     miss_d = '0;
                     if (prev_q[WIDTH-1]) lap_d = lap_q + LAP_W'(1);
                  end else begin
                     seq_d = 1'b1;
                     fault = 1'b1;
                  end
               end else begin
                  oh_d  = 1'b1;
                  fault = 1'b1;
               end
               if (fault) begin
                  if (miss_inc >= MW'(ERR_LIMIT)) begin
                     state_d = HUNT;
                     miss_d  = '0;
                  end else begin
                     miss_d = miss_inc;
                  end
               end
            end
            default: state_d = HUNT;
         endcase
      end
   end

   // State and output registers; reset aborts tracking without any pulse.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= HUNT;
         prev_q   <= '0;
         miss_q   <= '0;
         idx_q    <= '0;
         lap_q    <= '0;
         locked_q <= 1'b0;
         iv_q     <= 1'b0;
         seq_q    <= 1'b0;
         oh_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         prev_q   <= prev_d;
         miss_q   <= miss_d;
         idx_q    <= idx_d;
         lap_q    <= lap_d;
         locked_q <= (state_d == TRACK);
         iv_q     <= iv_d;
         seq_q    <= seq_d;
         oh_q     <= oh_d;
      end
   end

   assign idx_out    = idx_q;
   assign idx_valid  = iv_q;
   assign locked     = locked_q;
   assign seq_err    = seq_q;
   assign onehot_err = oh_q;
   assign lap_count  = lap_q;

endmodule

// File: tb/tb_ring_decoder.sv
// Self-checking bench for ring_decoder: directed scenarios plus randomized traffic
// compared against a position-based behavioural model.
module tb_ring_decoder;

   localparam int WIDTH     = 3;
   localparam int LAP_W     = 2;
   localparam int ERR_LIMIT = 2;
   localparam int IW        = 2;

   logic             clk;
   logic             reset_n;
   logic             in_valid;
   logic [WIDTH-1:0] ring_in;
   logic [IW-1:0]    idx_out;
   logic             idx_valid;
   logic             locked;
   logic             seq_err;
   logic             onehot_err;
   logic [LAP_W-1:0] lap_count;

   int total_cnt = 0;
   int fail_cnt  = 0;

   // Model state kept as integer positions rather than bit patterns.
   int m_prev;
   int m_locked;
   int m_miss;
   int m_laps;
   int e_idx;
   int e_iv;
   int e_seq;
   int e_oh;

   ring_decoder #(.WIDTH(WIDTH), .LAP_W(LAP_W), .ERR_LIMIT(ERR_LIMIT)) dut (
      .clk(clk),
      .reset_n(reset_n),
      .in_valid(in_valid),
      .ring_in(ring_in),
      .idx_out(idx_out),
      .idx_valid(idx_valid),
      .locked(locked),
      .seq_err(seq_err),
      .onehot_err(onehot_err),
      .lap_count(lap_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic model_reset();
      m_prev = 0; m_locked = 0; m_miss = 0; m_laps = 0;
      e_idx = 0; e_iv = 0; e_seq = 0; e_oh = 0;
   endtask

   task automatic model_step(input logic v, input logic [WIDTH-1:0] p);
      int ones;
      int where;
      e_iv = 0; e_seq = 0; e_oh = 0;
      if (!v) return;
      ones = 0; where = 0;
      for (int i = 0; i < WIDTH; i++) if (p[i]) begin ones++; where = i; end
      if (m_locked == 0) begin
         if (ones == 1) begin
            e_idx = where; e_iv = 1; m_prev = where; m_miss = 0; m_locked = 1;
         end else begin
            e_oh = 1;
         end
      end else if (ones == 1) begin
         e_iv = 1; e_idx = where;
         if (where == (m_prev + 1) % WIDTH) begin
            if (m_prev == WIDTH - 1) m_laps = (m_laps + 1) % (1 << LAP_W);
            m_miss = 0;
         end else begin
            e_seq = 1; m_miss++;
         end
         m_prev = where;
      end else begin
         e_oh = 1; m_miss++;
      end
      if (m_locked != 0 && m_miss >= ERR_LIMIT) begin
         m_locked = 0; m_miss = 0;
      end
   endtask

   function automatic logic [7:0] expected_vec();
      return {IW'(e_idx), e_iv[0], m_locked[0], e_seq[0], e_oh[0], LAP_W'(m_laps)};
   endfunction

   // Inputs are applied 1 time unit after an edge and outputs observed 1 unit after the next.
   task automatic applyStimulus(input logic v, input logic [WIDTH-1:0] p);
      in_valid = v;
      ring_in  = p;
      @(posedge clk);
      #1;
      model_step(v, p);
   endtask

   task automatic test_reset();
      reset_n = 1'b0; in_valid = 1'b0; ring_in = '0;
      model_reset();
      #12;
      total_cnt++;
      if ({idx_out, idx_valid, locked, seq_err, onehot_err, lap_count} !== 8'b0) begin
         fail_cnt++;
         $display("[TB] FAIL reset_state: actual=%b required=%b",
                  {idx_out, idx_valid, locked, seq_err, onehot_err, lap_count}, 8'b0);
      end
      @(negedge clk); reset_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_normal();
      logic [WIDTH-1:0] pats [5] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010};
      int idxs [5] = '{0, 1, 2, 0, 1};
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, pats[i]);
         total_cnt++;
         if ({idx_out, idx_valid, locked, seq_err, onehot_err, lap_count} !== expected_vec()
             || idx_out !== IW'(idxs[i])) begin
            fail_cnt++;
            $display("[TB] FAIL normal step %0d: actual {idx,iv,lk,se,oe,lap}=%b required=%b idx=%0d",
                     i, {idx_out, idx_valid, locked, seq_err, onehot_err, lap_count}, expected_vec(), idxs[i]);
         end
      end
      total_cnt++;
      if (lap_count !== 2'd1) begin
         fail_cnt++;
         $display("[TB] FAIL normal_lap: actual=%0d required=1", lap_count);
      end
   endtask

   task automatic test_skip();
      logic [WIDTH-1:0] pats [4] = '{3'b100, 3'b001, 3'b100, 3'b001};
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, pats[i]);
         total_cnt++;
         if ({idx_out, idx_valid, locked, seq_err, onehot_err, lap_count} !== expected_vec()) begin
            fail_cnt++;
            $display("[TB] FAIL skip step %0d: actual {idx,iv,lk,se,oe,lap}=%b required=%b",
                     i, {idx_out, idx_valid, locked, seq_err, onehot_err, lap_count}, expected_vec());
         end
         if (i == 2) begin
            total_cnt++;
            if (seq_err !== 1'b1 || idx_out !== 2'd2 || locked !== 1'b1) begin
               fail_cnt++;
               $display("[TB] FAIL skip_seq_err: actual se=%b idx=%0d lk=%b required se=1 idx=2 lk=1",
                        seq_err, idx_out, locked);
            end
         end
      end
   endtask

   task automatic test_loss_of_lock();
      logic [WIDTH-1:0] pats [4] = '{3'b010, 3'b011, 3'b000, 3'b100};
      logic [LAP_W-1:0] lap_before;
      lap_before = lap_count;
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, pats[i]);
         total_cnt++;
         if ({idx_out, idx_valid, locked, seq_err, onehot_err, lap_count} !== expected_vec()) begin
            fail_cnt++;
            $display("[TB] FAIL loss step %0d: actual {idx,iv,lk,se,oe,lap}=%b required=%b",
                     i, {idx_out, idx_valid, locked, seq_err, onehot_err, lap_count}, expected_vec());
         end
         if (i == 2) begin
            total_cnt++;
            if (locked !== 1'b0 || onehot_err !== 1'b1 || idx_out !== 2'd1) begin
               fail_cnt++;
               $display("[TB] FAIL loss_unlock: actual lk=%b oe=%b idx=%0d required lk=0 oe=1 idx=1",
                        locked, onehot_err, idx_out);
            end
         end
      end
      total_cnt++;
      if (locked !== 1'b1 || idx_out !== 2'd2 || lap_count !== lap_before) begin
         fail_cnt++;
         $display("[TB] FAIL loss_relock: actual lk=%b idx=%0d lap=%0d required lk=1 idx=2 lap=%0d",
                  locked, idx_out, lap_count, lap_before);
      end
   endtask

   task automatic test_gaps_and_repeat();
      logic             vs [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      logic [WIDTH-1:0] ps [6] = '{3'b001, 3'b111, 3'b000, 3'b001, 3'b010, 3'b010};
      for (int i = 0; i < 6; i++) begin
         applyStimulus(vs[i], ps[i]);
         total_cnt++;
         if ({idx_out, idx_valid, locked, seq_err, onehot_err, lap_count} !== expected_vec()) begin
            fail_cnt++;
            $display("[TB] FAIL gaps step %0d: actual {idx,iv,lk,se,oe,lap}=%b required=%b",
                     i, {idx_out, idx_valid, locked, seq_err, onehot_err, lap_count}, expected_vec());
         end
      end
   endtask

   task automatic test_lap_wrap();
      logic [WIDTH-1:0] lap_pats [3] = '{3'b010, 3'b100, 3'b001};
      int laps_req [5] = '{1, 2, 3, 0, 1};
      reset_n = 1'b0; #3; model_reset();
      @(negedge clk); reset_n = 1'b1;
      @(posedge clk); #1;
      applyStimulus(1'b1, 3'b001);
      for (int lap = 0; lap < 5; lap++) begin
         for (int s = 0; s < 3; s++) applyStimulus(1'b1, lap_pats[s]);
         total_cnt++;
         if (lap_count !== LAP_W'(laps_req[lap]) || lap_count !== LAP_W'(m_laps)) begin
            fail_cnt++;
            $display("[TB] FAIL lap_wrap lap %0d: actual=%0d required=%0d", lap, lap_count, laps_req[lap]);
         end
      end
   endtask

   task automatic test_random();
      logic             v;
      logic [WIDTH-1:0] p;
      for (int i = 0; i < 300; i++) begin
         v = ($urandom_range(0, 4) != 0);
         if (m_locked != 0 && $urandom_range(0, 9) < 6) p = WIDTH'(1 << ((m_prev + 1) % WIDTH));
         else p = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
         applyStimulus(v, p);
         total_cnt++;
         if ({idx_out, idx_valid, locked, seq_err, onehot_err, lap_count} !== expected_vec()) begin
            fail_cnt++;
            $display("[TB] FAIL random step %0d (v=%b p=%b): actual {idx,iv,lk,se,oe,lap}=%b required=%b",
                     i, v, p, {idx_out, idx_valid, locked, seq_err, onehot_err, lap_count}, expected_vec());
         end
      end
   endtask

   task automatic test_reset_mid();
      applyStimulus(1'b1, 3'b111);
      applyStimulus(1'b1, 3'b111);
      applyStimulus(1'b1, 3'b001);
      applyStimulus(1'b1, 3'b010);
      total_cnt++;
      if (locked !== 1'b1 || idx_out !== 2'd1) begin
         fail_cnt++;
         $display("[TB] FAIL midreset_prelock: actual lk=%b idx=%0d required lk=1 idx=1", locked, idx_out);
      end
      in_valid = 1'b0;
      #2 reset_n = 1'b0;
      #1;
      model_reset();
      total_cnt++;
      if ({idx_out, idx_valid, locked, seq_err, onehot_err, lap_count} !== 8'b0) begin
         fail_cnt++;
         $display("[TB] FAIL midreset_async: actual=%b required=%b",
                  {idx_out, idx_valid, locked, seq_err, onehot_err, lap_count}, 8'b0);
      end
      @(negedge clk); reset_n = 1'b1;
      @(posedge clk); #1;
      applyStimulus(1'b1, 3'b100);
      total_cnt++;
      if ({idx_out, idx_valid, locked, seq_err, onehot_err, lap_count} !== 8'b10_1_1_0_0_00) begin
         fail_cnt++;
         $display("[TB] FAIL midreset_relock: actual=%b required=%b",
                  {idx_out, idx_valid, locked, seq_err, onehot_err, lap_count}, 8'b10_1_1_0_0_00);
      end
   endtask

   initial begin
      test_reset();
      test_normal();
      test_skip();
      test_loss_of_lock();
      test_gaps_and_repeat();
      test_lap_wrap();
      test_random();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", total_cnt, fail_cnt);
      $finish;
   end

endmodule
